// File: rtl/cacheline_adaptor_pkg.sv
// Shared line/beat types and burst geometry for the cache-side memory interface.
// Caches and the arbiter reuse these so every line port agrees on width.
package cacheline_adaptor_pkg;

    localparam int CL_LINE_WIDTH = 256;
    localparam int CL_BEAT_WIDTH = 64;
    localparam int CL_ADDR_WIDTH = 32;
    localparam int BURST_LEN     = CL_LINE_WIDTH / CL_BEAT_WIDTH;

    typedef logic [CL_LINE_WIDTH-1:0] cacheline_t;
    typedef logic [CL_BEAT_WIDTH-1:0] beat_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Splits each 256-bit line read/write into a 4-beat 64-bit memory burst and
// reassembles read beats into a line, answering with a one-cycle line_resp.
module cacheline_adaptor
    import cacheline_adaptor_pkg::*;
#(
    parameter int LINE_WIDTH = CL_LINE_WIDTH,
    parameter int BEAT_WIDTH = CL_BEAT_WIDTH,
    parameter int ADDR_WIDTH = CL_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] line_address,
    input  logic                  line_read,
    input  logic                  line_write,
    input  logic [LINE_WIDTH-1:0] line_wdata,
    output logic [LINE_WIDTH-1:0] line_rdata,
    output logic                  line_resp,
    output logic [ADDR_WIDTH-1:0] burst_address,
    output logic                  burst_read,
    output logic                  burst_write,
    output logic [BEAT_WIDTH-1:0] burst_wdata,
    input  logic [BEAT_WIDTH-1:0] burst_rdata,
    input  logic                  burst_resp
);

    localparam int NUM_BEATS   = LINE_WIDTH / BEAT_WIDTH;
    localparam int LINE_OFFSET = $clog2(LINE_WIDTH / 8);
    localparam int CNT_W       = $clog2(NUM_BEATS);

    localparam logic [CNT_W-1:0]      LAST_BEAT  = CNT_W'(NUM_BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'((64'd1 << LINE_OFFSET) - 64'd1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_GAP   = 3'd4
    } state_e;

    state_e                state_q,         state_d;
    logic [CNT_W-1:0]      beat_cnt_q,      beat_cnt_d;
    logic [LINE_WIDTH-1:0] wline_q,         wline_d;
    logic [LINE_WIDTH-1:0] line_rdata_q,    line_rdata_d;
    logic                  line_resp_q,     line_resp_d;
    logic [ADDR_WIDTH-1:0] burst_address_q, burst_address_d;
    logic                  burst_read_q,    burst_read_d;
    logic                  burst_write_q,   burst_write_d;
    logic [BEAT_WIDTH-1:0] burst_wdata_q,   burst_wdata_d;
    logic [CNT_W-1:0]      next_cnt_s;

    // Next-state and next-output computation for the burst sequencer.
    always_comb begin
        state_d         = state_q;
        beat_cnt_d      = beat_cnt_q;
        wline_d         = wline_q;
        line_rdata_d    = line_rdata_q;
        line_resp_d     = 1'b0;
        burst_address_d = burst_address_q;
        burst_read_d    = burst_read_q;
        burst_write_d   = burst_write_q;
        burst_wdata_d   = burst_wdata_q;
        next_cnt_s      = beat_cnt_q + CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                // Writeback wins so a dirty victim leaves before its refill.
                if (line_write) begin
                    state_d         = S_WRITE;
                    burst_address_d = line_address & ALIGN_MASK;
                    wline_d         = line_wdata;
                    beat_cnt_d      = {CNT_W{1'b0}};
                    burst_write_d   = 1'b1;
                    burst_wdata_d   = line_wdata[BEAT_WIDTH-1:0];
                end else if (line_read) begin
                    state_d         = S_READ;
                    burst_address_d = line_address & ALIGN_MASK;
                    beat_cnt_d      = {CNT_W{1'b0}};
                    burst_read_d    = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (burst_resp) begin
                    line_rdata_d[int'(beat_cnt_q) * BEAT_WIDTH +: BEAT_WIDTH] = burst_rdata;
                    beat_cnt_d = next_cnt_s;
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d      = S_DONE;
                        burst_read_d = 1'b0;
                    end else begin
                        state_d = S_READ;
                    end
                end else begin
                    state_d = S_READ;
                end
            end
            S_WRITE: begin
                if (burst_resp) begin
                    beat_cnt_d = next_cnt_s;
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d       = S_DONE;
                        burst_write_d = 1'b0;
                    end else begin
                        state_d       = S_WRITE;
                        burst_wdata_d = wline_q[int'(next_cnt_s) * BEAT_WIDTH +: BEAT_WIDTH];
                    end
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_DONE: begin
                line_resp_d = 1'b1;
                state_d     = S_GAP;
            end
            S_GAP: begin
                // Requests seen here belong to the transaction just answered.
                state_d = S_IDLE;
            end
            default: begin
                state_d       = S_IDLE;
                beat_cnt_d    = {CNT_W{1'b0}};
                burst_read_d  = 1'b0;
                burst_write_d = 1'b0;
            end
        endcase
    end

    // State and registered-output flops; reset discards any partial burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            beat_cnt_q      <= {CNT_W{1'b0}};
            wline_q         <= {LINE_WIDTH{1'b0}};
            line_rdata_q    <= {LINE_WIDTH{1'b0}};
            line_resp_q     <= 1'b0;
            burst_address_q <= {ADDR_WIDTH{1'b0}};
            burst_read_q    <= 1'b0;
            burst_write_q   <= 1'b0;
            burst_wdata_q   <= {BEAT_WIDTH{1'b0}};
        end else begin
            state_q         <= state_d;
            beat_cnt_q      <= beat_cnt_d;
            wline_q         <= wline_d;
            line_rdata_q    <= line_rdata_d;
            line_resp_q     <= line_resp_d;
            burst_address_q <= burst_address_d;
            burst_read_q    <= burst_read_d;
            burst_write_q   <= burst_write_d;
            burst_wdata_q   <= burst_wdata_d;
        end
    end

    assign line_rdata    = line_rdata_q;
    assign line_resp     = line_resp_q;
    assign burst_address = burst_address_q;
    assign burst_read    = burst_read_q;
    assign burst_write   = burst_write_q;
    assign burst_wdata   = burst_wdata_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: table vectors, hand-written
// corner sequences, and random transactions against a line-level model.
module tb_cacheline_adaptor;
    import cacheline_adaptor_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] line_address;
    logic        line_read, line_write;
    cacheline_t  line_wdata, line_rdata;
    logic        line_resp;
    logic [31:0] burst_address;
    logic        burst_read, burst_write;
    beat_t       burst_wdata, burst_rdata;
    logic        burst_resp;

    int n_vec = 0;
    int n_mis = 0;
    cacheline_t last_rline = '0;

    always #5 clk = ~clk;

    cacheline_adaptor dut (
        .clk(clk), .rst(rst),
        .line_address(line_address), .line_read(line_read), .line_write(line_write),
        .line_wdata(line_wdata), .line_rdata(line_rdata), .line_resp(line_resp),
        .burst_address(burst_address), .burst_read(burst_read), .burst_write(burst_write),
        .burst_wdata(burst_wdata), .burst_rdata(burst_rdata), .burst_resp(burst_resp)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        cacheline_t  wdata;
        cacheline_t  rline;
        logic [7:0]  pat;      // burst_resp per active cycle, LSB first; 1 afterwards
        int          exp_lat;  // clock edges from request to line_resp visible
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic cacheline_t rand_line();
        cacheline_t v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Accept-cycle + burst cycles (stalls included) + one completion cycle.
    function automatic int model_latency(input logic [7:0] pat);
        int accepted = 0;
        int cyc = 0;
        while (accepted < 4) begin
            if ((cyc >= 8) ? 1'b1 : pat[cyc]) accepted++;
            cyc++;
        end
        return cyc + 2;
    endfunction

    // Plays the memory side until line_resp; reports latency and protocol errors.
    task automatic serve(input logic [7:0] pat, input cacheline_t rline, input cacheline_t wline,
                         input logic [31:0] exp_addr, output int lat, output logic was_wr,
                         output cacheline_t rd_at_resp, output int errs);
        int  acc = 0;
        int  act_cyc = 0;
        logic done = 1'b0;
        lat = 0; was_wr = 1'b0; errs = 0; rd_at_resp = '0;
        while (!done && lat < 200) begin
            if (burst_read || burst_write) begin
                if (burst_address !== exp_addr) errs++;
                if (acc >= 4) errs++;
                if (burst_write) begin
                    was_wr = 1'b1;
                    if (acc < 4 && burst_wdata !== wline[acc*64 +: 64]) errs++;
                end
                burst_resp  = (act_cyc < 8) ? pat[act_cyc] : 1'b1;
                burst_rdata = (acc < 4) ? rline[acc*64 +: 64] : 64'h0;
                act_cyc++;
                if (burst_resp) acc++;
            end else begin
                burst_resp  = 1'b0;
                burst_rdata = {$urandom, $urandom};
            end
            step();
            lat++;
            if (line_resp) begin
                done = 1'b1;
                rd_at_resp = line_rdata;
            end
        end
        burst_resp = 1'b0;
        if (!done) lat = -1;
        if (acc != 4) errs++;
    endtask

    task automatic run_txn(input logic wr, input logic [31:0] addr, input cacheline_t wdata,
                           input cacheline_t rline, input logic [7:0] pat, input int exp_lat,
                           input logic [31:0] exp_addr, input string tag);
        int lat, errs;
        logic was_wr;
        cacheline_t rd, exp_rd;
        line_address = addr; line_wdata = wdata;
        line_write = wr; line_read = ~wr;
        serve(pat, rline, wdata, exp_addr, lat, was_wr, rd, errs);
        exp_rd = wr ? last_rline : rline;
        if (!wr) last_rline = rline;
        check({tag, ".latency"}, 256'(lat), 256'(exp_lat));
        check({tag, ".direction"}, 256'(was_wr), 256'(wr));
        check({tag, ".burst_protocol_errs"}, 256'(errs), 256'd0);
        check({tag, ".line_rdata"}, rd, exp_rd);
        // GAP cycle: requests dropped, spurious burst_resp must be ignored.
        line_read = 1'b0; line_write = 1'b0; line_address = $urandom;
        burst_resp = 1'b1; burst_rdata = {$urandom, $urandom};
        step();
        burst_resp = 1'b0;
        check({tag, ".resp_one_cycle"}, 256'(line_resp), 256'd0);
        check({tag, ".gap_idle_bus"}, 256'(burst_read | burst_write), 256'd0);
        check({tag, ".gap_rdata_kept"}, line_rdata, last_rline);
    endtask

    initial begin
        int lat, errs;
        logic was_wr;
        cacheline_t rd, r1, w1;
        vec_t v;

        vecs[0] = '{1'b0, 32'h0000_1234, 256'h0,
                    256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111,
                    8'hFF, 6, 32'h0000_1220};
        vecs[1] = '{1'b1, 32'h8000_00E0,
                    256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0,
                    256'h0, 8'h35, 8, 32'h8000_00E0};
        vecs[2] = '{1'b0, 32'h0000_003F, 256'h0,
                    256'hA0A1A2A3A4A5A6A7_B0B1B2B3B4B5B6B7_C0C1C2C3C4C5C6C7_D0D1D2D3D4D5D6D7,
                    8'h93, 10, 32'h0000_0020};
        vecs[3] = '{1'b1, 32'hFFFF_FFFF,
                    256'hFFFF0000FFFF0000_00FF00FF00FF00FF_0F0F0F0F0F0F0F0F_1234567812345678,
                    256'h0, 8'hFF, 6, 32'hFFFF_FFE0};
        vecs[4] = '{1'b0, 32'hDEAD_BEEF, 256'h0,
                    256'h5555555555555555_6666666666666666_7777777777777777_8888888888888888,
                    8'hF0, 10, 32'hDEAD_BEE0};

        line_address = 32'h0; line_read = 1'b0; line_write = 1'b0; line_wdata = '0;
        burst_rdata = 64'h0; burst_resp = 1'b0;
        rst = 1'b0;
        #2 rst = 1'b1;
        #10;
        check("reset.line_resp", 256'(line_resp), 256'd0);
        check("reset.burst_read", 256'(burst_read), 256'd0);
        check("reset.burst_write", 256'(burst_write), 256'd0);
        check("reset.burst_address", 256'(burst_address), 256'd0);
        check("reset.burst_wdata", 256'(burst_wdata), 256'd0);
        check("reset.line_rdata", line_rdata, 256'd0);
        step();
        #2 rst = 1'b0;

        // Spurious burst_resp while idle.
        burst_resp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            burst_rdata = {$urandom, $urandom};
            step();
        end
        burst_resp = 1'b0;
        check("idle_spurious.line_resp", 256'(line_resp), 256'd0);
        check("idle_spurious.burst_read", 256'(burst_read | burst_write), 256'd0);
        check("idle_spurious.line_rdata", line_rdata, 256'd0);

        for (int i = 0; i < 5; i++) begin
            v = vecs[i];
            run_txn(v.wr, v.addr, v.wdata, v.rline, v.pat, v.exp_lat, v.exp_addr,
                    $sformatf("vec%0d", i));
        end

        // Read and write together: write burst first, read after the gap.
        r1 = rand_line(); w1 = rand_line();
        line_address = 32'h0000_0040; line_wdata = w1; line_read = 1'b1; line_write = 1'b1;
        serve(8'hFF, r1, w1, 32'h0000_0040, lat, was_wr, rd, errs);
        check("both.first_is_write", 256'(was_wr), 256'd1);
        check("both.first_latency", 256'(lat), 256'd6);
        check("both.first_errs", 256'(errs), 256'd0);
        line_write = 1'b0;
        step();
        check("both.gap_no_burst", 256'(burst_read | burst_write | line_resp), 256'd0);
        serve(8'hFF, r1, w1, 32'h0000_0040, lat, was_wr, rd, errs);
        check("both.second_is_read", 256'(was_wr), 256'd0);
        check("both.second_latency", 256'(lat), 256'd6);
        check("both.second_errs", 256'(errs), 256'd0);
        check("both.second_rdata", rd, r1);
        last_rline = r1;
        line_read = 1'b0;
        step();
        check("both.second_gap", 256'(burst_read | line_resp), 256'd0);

        // Requester holds line_read past line_resp: gap ignores it, idle restarts.
        r1 = rand_line();
        line_address = 32'h0000_0200; line_read = 1'b1;
        serve(8'hFF, r1, w1, 32'h0000_0200, lat, was_wr, rd, errs);
        check("hold.latency", 256'(lat), 256'd6);
        check("hold.rdata", rd, r1);
        step();
        check("hold.gap_ignores_req", 256'(burst_read), 256'd0);
        step();
        check("hold.idle_restart", 256'(burst_read), 256'd1);
        line_read = 1'b0;
        w1 = rand_line();
        serve(8'hFF, w1, r1, 32'h0000_0200, lat, was_wr, rd, errs);
        check("hold.restart_latency", 256'(lat), 256'd5);
        check("hold.restart_errs", 256'(errs), 256'd0);
        check("hold.restart_rdata", rd, w1);
        last_rline = w1;
        step();
        check("hold.restart_gap", 256'(line_resp | burst_read), 256'd0);

        // Async reset after two of four read beats.
        r1 = rand_line();
        line_address = 32'h0000_1000; line_read = 1'b1;
        step();
        burst_resp = 1'b1;
        for (int i = 0; i < 2; i++) begin
            burst_rdata = r1[i*64 +: 64];
            step();
        end
        burst_resp = 1'b0;
        check("midreset.pre_burst_read", 256'(burst_read), 256'd1);
        #2 rst = 1'b1;
        #1;
        check("midreset.burst_read", 256'(burst_read), 256'd0);
        check("midreset.line_resp", 256'(line_resp), 256'd0);
        check("midreset.line_rdata", line_rdata, 256'd0);
        line_read = 1'b0;
        last_rline = '0;
        @(posedge clk);
        #3 rst = 1'b0;
        run_txn(1'b0, 32'h0000_0100, '0, rand_line(), 8'hFF, 6, 32'h0000_0100, "post_reset");

        // Random transactions against the line-level model.
        for (int i = 0; i < 30; i++) begin
            logic        wr;
            logic [31:0] addr;
            logic [7:0]  pat;
            wr   = 1'($urandom_range(0, 1));
            addr = $urandom;
            pat  = 8'($urandom);
            run_txn(wr, addr, rand_line(), rand_line(), pat, model_latency(pat),
                    addr - (addr % 32'd32), $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
